// File: rtl/rc4_phase_scheduler.sv
// ============================================================================
// Module   : rc4_phase_scheduler
// Purpose  : Sequences RC4 init / KSA / PRGA phases, owns the shared S-memory
//            port and steps the secret key on every PRGA reject.
//            Optional macro PHASE_TIMEOUT_EN adds a per-phase watchdog.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rc4_phase_scheduler #(
  parameter int               KEY_W          = 24,
  parameter logic [KEY_W-1:0] KEY_START      = 24'h000000,
  parameter logic [KEY_W-1:0] KEY_LAST       = 24'h3FFFFF,
  parameter int               ADDR_W         = 8,
  parameter int               TIMEOUT_CYCLES = 4096
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,

  output logic              init_start,
  input  logic              init_done,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic [7:0]        init_data,
  input  logic              init_wren,

  output logic              ksa_start,
  input  logic              ksa_done,
  input  logic [ADDR_W-1:0] ksa_addr,
  input  logic [7:0]        ksa_data,
  input  logic              ksa_wren,

  output logic              prga_start,
  input  logic              prga_done,
  input  logic              prga_pass,
  input  logic [ADDR_W-1:0] prga_addr,
  input  logic [7:0]        prga_data,
  input  logic              prga_wren,

  output logic [ADDR_W-1:0] s_addr,
  output logic [7:0]        s_data,
  output logic              s_wren,

  output logic [KEY_W-1:0]  secret_key,
  output logic              busy,
  output logic              key_found,
  output logic              exhausted,
  output logic              error
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_INIT      = 4'd1,
    S_GAP1      = 4'd2,
    S_KSA       = 4'd3,
    S_GAP2      = 4'd4,
    S_PRGA      = 4'd5,
    S_GAP3      = 4'd6,
    S_FOUND     = 4'd7,
    S_EXHAUSTED = 4'd8,
    S_ERROR     = 4'd9
  } state_t;

  state_t r_state;
  state_t w_gap_next;
  logic   w_phase_done;
  logic   w_in_phase;
  logic   r_pass;

`ifdef PHASE_TIMEOUT_EN
  localparam int                c_tmr_w    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [c_tmr_w-1:0] c_tmr_last = c_tmr_w'(TIMEOUT_CYCLES - 1);
  logic [c_tmr_w-1:0] r_timer;
`endif

  // A done that coincides with its own start pulse is a stale level and is ignored.
  always_comb begin
    w_phase_done = 1'b0;
    w_in_phase   = 1'b0;
    w_gap_next   = S_IDLE;
    s_addr       = '0;
    s_data       = '0;
    s_wren       = 1'b0;
    case (r_state)
      S_INIT: begin
        w_in_phase   = 1'b1;
        w_phase_done = init_done & ~init_start;
        w_gap_next   = S_GAP1;
        s_addr       = init_addr;
        s_data       = init_data;
        s_wren       = init_wren;
      end
      S_KSA: begin
        w_in_phase   = 1'b1;
        w_phase_done = ksa_done & ~ksa_start;
        w_gap_next   = S_GAP2;
        s_addr       = ksa_addr;
        s_data       = ksa_data;
        s_wren       = ksa_wren;
      end
      S_PRGA: begin
        w_in_phase   = 1'b1;
        w_phase_done = prga_done & ~prga_start;
        w_gap_next   = S_GAP3;
        s_addr       = prga_addr;
        s_data       = prga_data;
        s_wren       = prga_wren;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      init_start <= 1'b0;
      ksa_start  <= 1'b0;
      prga_start <= 1'b0;
      secret_key <= KEY_START;
      busy       <= 1'b0;
      key_found  <= 1'b0;
      exhausted  <= 1'b0;
      r_pass     <= 1'b0;
`ifdef PHASE_TIMEOUT_EN
      error      <= 1'b0;
      r_timer    <= '0;
`endif
    end else begin
      init_start <= 1'b0;
      ksa_start  <= 1'b0;
      prga_start <= 1'b0;
`ifdef PHASE_TIMEOUT_EN
      // Every phase is entered from a non-phase state, so the watchdog starts at zero.
      if (!w_in_phase) r_timer <= '0;
`endif
      case (r_state)
        S_IDLE, S_FOUND, S_EXHAUSTED
`ifdef PHASE_TIMEOUT_EN
        , S_ERROR
`endif
        : begin
          if (start) begin
            secret_key <= KEY_START;
            key_found  <= 1'b0;
            exhausted  <= 1'b0;
`ifdef PHASE_TIMEOUT_EN
            error      <= 1'b0;
`endif
            busy       <= 1'b1;
            init_start <= 1'b1;
            r_state    <= S_INIT;
          end
        end
        S_INIT, S_KSA, S_PRGA: begin
          if (w_phase_done) begin
            r_state <= w_gap_next;
            if (r_state == S_PRGA) r_pass <= prga_pass;
          end
`ifdef PHASE_TIMEOUT_EN
          else if (r_timer == c_tmr_last) begin
            r_state <= S_ERROR;
            error   <= 1'b1;
            busy    <= 1'b0;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
`endif
        end
        S_GAP1: begin
          ksa_start <= 1'b1;
          r_state   <= S_KSA;
        end
        S_GAP2: begin
          prga_start <= 1'b1;
          r_state    <= S_PRGA;
        end
        S_GAP3: begin
          if (r_pass) begin
            key_found <= 1'b1;
            busy      <= 1'b0;
            r_state   <= S_FOUND;
          end else if (secret_key == KEY_LAST) begin
            exhausted <= 1'b1;
            busy      <= 1'b0;
            r_state   <= S_EXHAUSTED;
          end else begin
            secret_key <= secret_key + 1'b1;
            init_start <= 1'b1;
            r_state    <= S_INIT;
          end
        end
        default: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

`ifndef PHASE_TIMEOUT_EN
  // Without the watchdog, TIMEOUT_CYCLES only keeps the parameter list uniform.
  if (TIMEOUT_CYCLES < 0) begin : g_timeout_unused
  end
  assign error = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rc4_phase_scheduler.sv
// ============================================================================
// Module   : tb_rc4_phase_scheduler
// Purpose  : Self-checking bench for rc4_phase_scheduler with engine models.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rc4_phase_scheduler;

  localparam logic [23:0] c_key_start = 24'h000010;
  localparam logic [23:0] c_key_last  = 24'h000013;
  localparam int          c_timeout   = 16;
`ifdef PHASE_TIMEOUT_EN
  localparam int          c_max_lat   = 12;
`else
  localparam int          c_max_lat   = 1000;
`endif

  logic        clk, reset_n, start;
  logic        init_start, init_done, init_wren;
  logic [7:0]  init_addr, init_data;
  logic        ksa_start, ksa_done, ksa_wren;
  logic [7:0]  ksa_addr, ksa_data;
  logic        prga_start, prga_done, prga_pass, prga_wren;
  logic [7:0]  prga_addr, prga_data;
  logic [7:0]  s_addr, s_data;
  logic        s_wren;
  logic [23:0] secret_key;
  logic        busy, key_found, exhausted, error;

  rc4_phase_scheduler #(
    .KEY_W(24), .KEY_START(c_key_start), .KEY_LAST(c_key_last),
    .ADDR_W(8), .TIMEOUT_CYCLES(c_timeout)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .init_start(init_start), .init_done(init_done), .init_addr(init_addr),
    .init_data(init_data), .init_wren(init_wren),
    .ksa_start(ksa_start), .ksa_done(ksa_done), .ksa_addr(ksa_addr),
    .ksa_data(ksa_data), .ksa_wren(ksa_wren),
    .prga_start(prga_start), .prga_done(prga_done), .prga_pass(prga_pass),
    .prga_addr(prga_addr), .prga_data(prga_data), .prga_wren(prga_wren),
    .s_addr(s_addr), .s_data(s_data), .s_wren(s_wren),
    .secret_key(secret_key), .busy(busy), .key_found(key_found),
    .exhausted(exhausted), .error(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int init_lat = 1, ksa_lat = 1, prga_lat = 1;
  int rej_left = 0;
  int n_init = 0, n_ksa = 0, n_prga = 0;
  int owner = 0;    // phase the bench believes holds the port: 0 none, 1 init, 2 ksa, 3 prga
  int last_ph = 0;
  logic [2:0] prev_starts = 3'b000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int clip(input int v);
    return (v > c_max_lat) ? c_max_lat : v;
  endfunction

  // Reference: the search walks keys upward from KEY_START; rej rejects precede a pass.
  function automatic void model(input int rej, output logic [23:0] k, output bit f, output int n);
    int range;
    range = int'(c_key_last) - int'(c_key_start) + 1;
    if (rej < range) begin
      k = c_key_start + 24'(rej); f = 1'b1; n = rej + 1;
    end else begin
      k = c_key_last; f = 1'b0; n = range;
    end
  endfunction

  // Requester traffic: init/prga random, ksa holds a fixed write to 0xAA.
  initial begin
    init_addr = 8'h11; init_data = 8'h21; init_wren = 1'b1;
    ksa_addr  = 8'hAA; ksa_data  = 8'h5A; ksa_wren  = 1'b1;
    prga_addr = 8'h33; prga_data = 8'h23; prga_wren = 1'b1;
    forever begin
      @(posedge clk); #1;
      init_addr = 8'($urandom); init_data = 8'($urandom); init_wren = 1'($urandom);
      prga_addr = 8'($urandom); prga_data = 8'($urandom); prga_wren = 1'($urandom);
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (init_start === 1'b1 && init_lat > 0) begin
        repeat (init_lat) @(posedge clk);
        #1 init_done = 1'b1;
        @(posedge clk);
        #1 init_done = 1'b0;
      end
    end
  end

  initial begin
    ksa_done = 1'b0;
    forever begin
      @(negedge clk);
      if (ksa_start === 1'b1 && ksa_lat > 0) begin
        repeat (ksa_lat) @(posedge clk);
        #1 ksa_done = 1'b1;
        @(posedge clk);
        #1 ksa_done = 1'b0;
      end
    end
  end

  initial begin
    prga_done = 1'b0; prga_pass = 1'b0;
    forever begin
      @(negedge clk);
      if (prga_start === 1'b1 && prga_lat > 0) begin
        repeat (prga_lat) @(posedge clk);
        #1 prga_done = 1'b1;
        prga_pass = (rej_left == 0);
        if (rej_left > 0) rej_left--;
        @(posedge clk);
        #1 prga_done = 1'b0;
      end
    end
  end

  initial forever begin
    @(negedge reset_n);
    owner = 0; last_ph = 0;
  end

  // Protocol monitor: start order, pulse width, key at each attempt, port ownership.
  initial forever begin
    @(negedge clk);
    if (reset_n === 1'b1) begin
      if (error === 1'b1) owner = 0;
      if (|{init_start, ksa_start, prga_start})
        chk("start_pulse_width", 32'({init_start, ksa_start, prga_start} & prev_starts), 0);
      if (init_start) begin
        chk("init_order", 32'(last_ph == 0 || last_ph == 3), 1);
        chk("key_at_init", secret_key, c_key_start + 24'(n_init));
        chk("busy_at_init", busy, 1);
        n_init++; owner = 1; last_ph = 1;
      end
      if (ksa_start) begin
        chk("ksa_order", 32'(last_ph == 1), 1);
        n_ksa++; owner = 2; last_ph = 2;
      end
      if (prga_start) begin
        chk("prga_order", 32'(last_ph == 2), 1);
        n_prga++; owner = 3; last_ph = 3;
      end
      case (owner)
        1:       chk("port_init", {s_addr, s_data, s_wren}, {init_addr, init_data, init_wren});
        2:       chk("port_ksa",  {s_addr, s_data, s_wren}, {ksa_addr, ksa_data, ksa_wren});
        3:       chk("port_prga", {s_addr, s_data, s_wren}, {prga_addr, prga_data, prga_wren});
        default: chk("port_idle", {s_addr, s_data, s_wren}, 0);
      endcase
      if (owner == 1 && init_done && !init_start) owner = 0;
      if (owner == 2 && ksa_done  && !ksa_start)  owner = 0;
      if (owner == 3 && prga_done && !prga_start) owner = 0;
      prev_starts = {init_start, ksa_start, prga_start};
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic run(input int rej, input int li, input int lk, input int lp,
                     input logic [23:0] ek, input bit ef, input int ei);
    bit ended;
    init_lat = li; ksa_lat = lk; prga_lat = lp; rej_left = rej;
    n_init = 0; n_ksa = 0; n_prga = 0;
    pulse_start();
    ended = 1'b0;
    for (int c = 0; c < 20000; c++) begin
      @(negedge clk);
      if (key_found || exhausted) begin ended = 1'b1; break; end
    end
    chk("search_ends", 32'(ended), 1);
    chk("key_found", key_found, 32'(ef));
    chk("exhausted", exhausted, 32'(!ef));
    chk("secret_key", secret_key, ek);
    chk("busy_end", busy, 0);
    chk("error_end", error, 0);
    repeat (20) @(negedge clk);
    chk("init_count", n_init, ei);
    chk("ksa_count", n_ksa, ei);
    chk("prga_count", n_prga, ei);
    chk("key_hold", secret_key, ek);
  endtask

  typedef struct {
    int          rej;
    int          li, lk, lp;
    logic [23:0] exp_key;
    bit          exp_found;
    int          exp_inits;
  } vec_t;

  vec_t vecs [5];

  initial begin
    bit          seen;
    logic [23:0] mk;
    bit          mf;
    int          mn;
    int          r;

    vecs[0] = '{0,  256, 768, 64, 24'h000010, 1'b1, 1};
    vecs[1] = '{2,  3,   4,   5,  24'h000012, 1'b1, 3};
    vecs[2] = '{3,  1,   1,   1,  24'h000013, 1'b1, 4};
    vecs[3] = '{4,  2,   2,   2,  24'h000013, 1'b0, 4};
    vecs[4] = '{10, 1,   2,   1,  24'h000013, 1'b0, 4};

    reset_n = 1'b0; start = 1'b0; init_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_starts", {init_start, ksa_start, prga_start}, 0);
    chk("rst_port", {s_addr, s_data, s_wren}, 0);
    chk("rst_key", secret_key, c_key_start);
    chk("rst_flags", {busy, key_found, exhausted, error}, 0);
    reset_n = 1'b1;

    for (int i = 0; i < 5; i++)
      run(vecs[i].rej, clip(vecs[i].li), clip(vecs[i].lk), clip(vecs[i].lp),
          vecs[i].exp_key, vecs[i].exp_found, vecs[i].exp_inits);

    for (int i = 0; i < 10; i++) begin
      r = int'($urandom_range(0, 6));
      model(r, mk, mf, mn);
      run(r, int'($urandom_range(1, 12)), int'($urandom_range(1, 12)),
          int'($urandom_range(1, 12)), mk, mf, mn);
    end

    // Stale init_done level: first INIT cycle must not complete the phase.
    init_lat = 0; ksa_lat = 3; prga_lat = 3; rej_left = 0;
    n_init = 0; n_ksa = 0; n_prga = 0;
    init_done = 1'b1;
    pulse_start();
    @(negedge clk); chk("stale_init_start", init_start, 1);
    @(negedge clk); chk("stale_done_held", {s_addr, s_data, s_wren}, {init_addr, init_data, init_wren});
    chk("stale_no_ksa", ksa_start, 0);
    @(negedge clk); chk("gap1_write_free", s_wren, 0);
    @(negedge clk); chk("ksa_after_gap", ksa_start, 1);
    @(posedge clk); #1 init_done = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (key_found) begin seen = 1'b1; break; end
    end
    chk("stale_found", 32'(seen), 1);
    chk("stale_key", secret_key, c_key_start);

    // Reset in the middle of KSA.
    init_lat = 2; ksa_lat = 200; prga_lat = 2;
    n_init = 0; n_ksa = 0; n_prga = 0;
    pulse_start();
    seen = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (n_ksa == 1) begin seen = 1'b1; break; end
    end
    chk("reach_ksa", 32'(seen), 1);
    repeat (5) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_port", {s_addr, s_data, s_wren}, 0);
    chk("midrst_busy", busy, 0);
    @(posedge clk); #1 reset_n = 1'b1;
    repeat (300) @(negedge clk);
    chk("midrst_no_init", n_init, 1);
    chk("midrst_no_ksa", n_ksa, 1);
    chk("midrst_no_prga", n_prga, 0);
    chk("midrst_idle", {busy, key_found, exhausted}, 0);

    // KSA never finishes.
    init_lat = 2; ksa_lat = -1; prga_lat = 2;
    n_init = 0; n_ksa = 0; n_prga = 0;
    pulse_start();
    seen = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (ksa_start) begin seen = 1'b1; break; end
    end
    chk("reach_ksa_to", 32'(seen), 1);
`ifdef PHASE_TIMEOUT_EN
    repeat (c_timeout - 1) @(negedge clk);
    chk("error_not_early", error, 0);
    @(negedge clk);
    chk("error_on_time", error, 1);
    chk("error_port_idle", {s_addr, s_data, s_wren}, 0);
    chk("error_busy", busy, 0);
`else
    repeat (100) @(negedge clk);
    chk("ksa_waits_busy", busy, 1);
    chk("ksa_waits_no_prga", n_prga, 0);
    chk("ksa_waits_port", {s_addr, s_wren}, {8'hAA, 1'b1});
    chk("no_error", error, 0);
`endif
    #2 reset_n = 1'b0;
    @(posedge clk); #1 reset_n = 1'b1;
    ksa_lat = 2;
    run(1, 2, 2, 2, 24'h000011, 1'b1, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
